// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and constants for the memory bus scheduler.
// The state enum and requester index type live here.
// The access-size codes are shared with the core's bus port.
package mem_sched_pkg;

   // Scheduler states: ARB = no owner, OWN = one requester holds the bus
   typedef enum logic {
      ARB = 1'b0,
      OWN = 1'b1
   } state_e;

   // Default requester count: core, DMA, video refresh
   localparam int NREQ_DEF = 3;
   localparam int NREQ_MAX = 8;

   // Requester index type for the default configuration
   typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;

   // Access size encoding on the r/w/sz/addr/busy handshake
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// It searches upward from the requester after last_grant and wraps from
// NREQ-1 back to 0. The first active requester wins.
module rr_pick
   import mem_sched_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    any_req
);

   localparam int IDW = $clog2(NREQ);

   // cand[k] is the requester examined k+1 places after last_grant
   logic [NREQ-1:0][IDW-1:0] cand;
   logic [NREQ-1:0]          hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand[gi] = IDW'((int'(last_grant) + gi + 1) % NREQ);
         assign hit[gi]  = req[cand[gi]];
      end
   endgenerate

   assign any_req = |req;

   // The lowest rotation offset with an active request wins.
   // The scan runs downward so the nearest hit is written last.
   always_comb begin
      winner = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            winner = cand[k];
         end
      end
   end

endmodule

// File: rtl/mem_sched.sv
// mem_sched: round-robin owner of the single external memory bus.
// Requester 0 is the core; the others are DMA and video refresh.
// A grant is held until the memory completes the transfer, or until the
// owner abandons its request.
// Optional feature macro: MEM_SCHED_LOCK_EN. When it is defined, req_lock
// lets an owner keep the bus for up to MAX_LOCK back-to-back transfers.
module mem_sched
   import mem_sched_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int MAX_LOCK = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_r,
   input  logic [NREQ-1:0]         req_w,
   input  logic [NREQ-1:0][1:0]    req_sz,
   input  logic [NREQ-1:0][31:0]   req_addr,
   input  logic [NREQ-1:0][31:0]   req_wdata,
   input  logic [NREQ-1:0]         req_lock,
   output logic [31:0]             req_rdata,
   output logic [NREQ-1:0]         req_busy,
   output logic                    mem_r,
   output logic                    mem_w,
   output logic [1:0]              mem_sz,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   input  logic                    mem_busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int IDW = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;

   logic [NREQ-1:0]  req_act;
   logic             own_act;
   logic             any_req;
   logic [IDW-1:0]   pick;

   assign req_act = req_r | req_w;
   assign own_act = req_act[owner_q];

`ifdef MEM_SCHED_LOCK_EN
   localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic             lock_more;

   // Stay locked only while the owner asks for it and the burst cap is not reached
   assign lock_more = req_lock[owner_q] && (lock_cnt_q < LCW'(MAX_LOCK - 1));
`else
   // Without locking, req_lock and MAX_LOCK have no effect on the design
   localparam int unused_max_lock = MAX_LOCK;
   logic unused_lock;
   assign unused_lock = ^req_lock;
`endif

   // Pick the next owner by rotating priority after last_grant
   rr_pick #(
      .NREQ       (NREQ)
   ) u_pick (
      .req        (req_act),
      .last_grant (last_grant_q),
      .winner     (pick),
      .any_req    (any_req)
   );

   // State, owner and rotation pointer; reset drops the bus asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB;
         owner_q      <= '0;
         last_grant_q <= IDW'(NREQ - 1);
`ifdef MEM_SCHED_LOCK_EN
         lock_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
`ifdef MEM_SCHED_LOCK_EN
         lock_cnt_q   <= lock_cnt_d;
`endif
      end
   end

   // Next state: grant on any request, release on completion or abandon
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
`ifdef MEM_SCHED_LOCK_EN
      lock_cnt_d   = lock_cnt_q;
`endif
      unique case (state_q)
         ARB: begin
            if (any_req) begin
               state_d      = OWN;
               owner_d      = pick;
               last_grant_d = pick;
            end
         end
         OWN: begin
            if (!own_act) begin
               // The owner withdrew before completion; no transfer took place
               state_d = ARB;
`ifdef MEM_SCHED_LOCK_EN
               lock_cnt_d = '0;
`endif
            end else if (!mem_busy) begin
`ifdef MEM_SCHED_LOCK_EN
               if (lock_more) begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end else begin
                  state_d    = ARB;
                  lock_cnt_d = '0;
               end
`else
               state_d = ARB;
`endif
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // Bus path: the owner's request passes straight to memory; no owner means an idle bus
   always_comb begin
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      mem_sz    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      req_busy  = '1;
      if (state_q == OWN) begin
         mem_r             = req_r[owner_q];
         mem_w             = req_w[owner_q];
         mem_sz            = req_sz[owner_q];
         mem_addr          = req_addr[owner_q];
         mem_wdata         = req_wdata[owner_q];
         req_busy[owner_q] = mem_busy;
      end
   end

   assign req_rdata = mem_rdata;
   assign grant_id  = owner_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: self-checking bench for mem_sched.
// It uses per-cycle vector tables for the directed bus sequences.
// A completion scoreboard checks grant order and the data at completion.
`timescale 1ns/1ps
module tb_mem_sched;
   import mem_sched_pkg::*;

   localparam int NREQ     = 3;
   localparam int MAX_LOCK = 4;
   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2000;
   localparam logic [31:0] A2 = 32'h0000_3000;
   localparam logic [31:0] RD = 32'hDEAD_BEEF;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_r, req_w, req_lock;
   logic [NREQ-1:0][1:0]  req_sz;
   logic [NREQ-1:0][31:0] req_addr, req_wdata;
   logic [31:0]           req_rdata;
   logic [NREQ-1:0]       req_busy;
   logic                  mem_r, mem_w;
   logic [1:0]            mem_sz;
   logic [31:0]           mem_addr, mem_wdata, mem_rdata;
   logic                  mem_busy;
   logic [1:0]            grant_id;

   always #5 clk = ~clk;

   mem_sched #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst(rst),
      .req_r(req_r), .req_w(req_w), .req_sz(req_sz), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_lock(req_lock),
      .req_rdata(req_rdata), .req_busy(req_busy),
      .mem_r(mem_r), .mem_w(mem_w), .mem_sz(mem_sz), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
      .grant_id(grant_id)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- completion scoreboard ----------------
   typedef struct {
      int          id;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   done_id[$];
   int   done_cyc[$];

   task automatic expect_xfer(input int id, input logic rd, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.id = id; e.rd = rd; e.addr = addr; e.data = data;
      sb.push_back(e);
   endtask

   int   mon_nlow, mon_id;
   exp_t mon_e;
   // Each low req_busy is one completed transfer; compare it against the oldest expected one
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mon_nlow = 0;
         mon_id   = -1;
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_busy[i] === 1'b0) begin
               mon_nlow++;
               mon_id = i;
            end
         end
         if (mon_nlow != 0) begin
            chk("single_done", 32'(mon_nlow), 32'd1);
            done_id.push_back(mon_id);
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: requester %0d completed, none expected (t=%0t)", mon_id, $time);
            end else begin
               mon_e = sb.pop_front();
               $display("xfer cyc=%0d id=%0d %s addr=0x%08h data=0x%08h", cyc, mon_id,
                        mon_e.rd ? "RD" : "WR", mem_addr, mon_e.rd ? req_rdata : mem_wdata);
               chk("done_id", 32'(mon_id), 32'(mon_e.id));
               chk("done_grant_id", 32'(grant_id), 32'(mon_e.id));
               chk("done_addr", mem_addr, mon_e.addr);
               if (mon_e.rd) begin
                  chk("done_rdata", req_rdata, mon_e.data);
                  chk("done_mem_r", 32'(mem_r), 32'd1);
               end else begin
                  chk("done_wdata", mem_wdata, mon_e.data);
                  chk("done_mem_w", 32'(mem_w), 32'd1);
               end
            end
         end
      end
   end

   // ---------------- per-cycle vector tables ----------------
   typedef struct {
      logic [2:0]  r, w;
      logic        mb;
      logic        exp_r, exp_w;
      logic [1:0]  exp_sz;
      logic [2:0]  exp_busy;
      logic [31:0] exp_addr, exp_wdata;
      logic        gchk;
      logic [1:0]  exp_gid;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t row(input logic [2:0] r, input logic [2:0] w, input logic mb,
                                input logic er, input logic ew, input logic [1:0] esz,
                                input logic [2:0] eb, input logic [31:0] ea, input logic [31:0] ed,
                                input logic gc, input logic [1:0] eg);
      vec_t v;
      v.r = r; v.w = w; v.mb = mb; v.exp_r = er; v.exp_w = ew; v.exp_sz = esz;
      v.exp_busy = eb; v.exp_addr = ea; v.exp_wdata = ed; v.gchk = gc; v.exp_gid = eg;
      return v;
   endfunction

   // Drive one row per cycle and check the bus outputs at the falling edge
   task automatic run_tab(input string tag);
      for (int i = 0; i < tab.size(); i++) begin
         req_r    = tab[i].r;
         req_w    = tab[i].w;
         mem_busy = tab[i].mb;
         @(negedge clk);
         chk($sformatf("%s[%0d].mem_r", tag, i), 32'(mem_r), 32'(tab[i].exp_r));
         chk($sformatf("%s[%0d].mem_w", tag, i), 32'(mem_w), 32'(tab[i].exp_w));
         chk($sformatf("%s[%0d].mem_sz", tag, i), 32'(mem_sz), 32'(tab[i].exp_sz));
         chk($sformatf("%s[%0d].mem_addr", tag, i), mem_addr, tab[i].exp_addr);
         chk($sformatf("%s[%0d].mem_wdata", tag, i), mem_wdata, tab[i].exp_wdata);
         chk($sformatf("%s[%0d].req_busy", tag, i), 32'(req_busy), 32'(tab[i].exp_busy));
         if (tab[i].gchk) begin
            chk($sformatf("%s[%0d].grant_id", tag, i), 32'(grant_id), 32'(tab[i].exp_gid));
         end
         tick();
      end
      tab.delete();
   endtask

   // Wait (bounded) for a requester's completion cycle, then move past it
   task automatic wait_done(input int id, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_busy[id] !== 1'b0 && n < budget);
      if (req_busy[id] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL wait_done_%0d: no completion within %0d cycles", id, budget);
      end
      tick();
   endtask

   // ---------------- stimulus ----------------
   int n0, n1;
   logic done0;
   int lk_id[7];
   int lk_gap[6];

   initial begin
      req_r = '0; req_w = '0; req_lock = '0; req_sz = '0; req_wdata = '0;
      req_addr[0] = A0; req_addr[1] = A1; req_addr[2] = A2;
      req_sz[0] = SZ_WORD; req_sz[1] = SZ_WORD; req_sz[2] = SZ_WORD;
      mem_rdata = RD; mem_busy = 1'b0;

      // 1) reset values, then requesters 0 and 2 reading: 0 first, 2 next
      rst   = 1'b0;
      req_r = 3'b101;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.mem_r", 32'(mem_r), 32'd0);
      chk("rst.mem_w", 32'(mem_w), 32'd0);
      chk("rst.mem_sz", 32'(mem_sz), 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.mem_wdata", mem_wdata, 32'd0);
      chk("rst.req_busy", 32'(req_busy), 32'b111);
      chk("rst.grant_id", 32'(grant_id), 32'd0);
      expect_xfer(0, 1'b1, A0, RD);
      expect_xfer(2, 1'b1, A2, RD);
      tick();
      rst = 1'b1;
      wait_done(0, 10);
      req_r[0] = 1'b0;
      wait_done(2, 10);
      req_r[2] = 1'b0;

      // 2) all three continuously reading: 0,1,2,0,1,2 with one completion every 2 cycles
      rst = 1'b0;
      @(negedge clk);
      tick();
      for (int k = 0; k < 6; k++) begin
         expect_xfer(k % 3, 1'b1, (k % 3 == 0) ? A0 : ((k % 3 == 1) ? A1 : A2), RD);
      end
      n0    = done_id.size();
      req_r = 3'b111;
      rst   = 1'b1;
      repeat (12) @(negedge clk);
      tick();
      req_r = 3'b000;
      chk("rot.count", 32'(done_id.size() - n0), 32'd6);
      for (int k = 1; k < 6; k++) begin
         if (n0 + k < done_cyc.size()) begin
            chk($sformatf("rot.gap%0d", k), 32'(done_cyc[n0 + k] - done_cyc[n0 + k - 1]), 32'd2);
         end
      end

      // 3) requester 1 writes a word with memory busy for 3 cycles
      req_addr[1]  = 32'h0000_0100;
      req_wdata[1] = 32'h1234_5678;
      expect_xfer(1, 1'b0, 32'h0000_0100, 32'h1234_5678);
      tab.push_back(row(3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 32'h0, 32'h0, 1'b0, 2'd0));
      tab.push_back(row(3'b000, 3'b010, 1'b1, 1'b0, 1'b1, SZ_WORD, 3'b111, 32'h100, 32'h12345678, 1'b1, 2'd1));
      tab.push_back(row(3'b000, 3'b010, 1'b1, 1'b0, 1'b1, SZ_WORD, 3'b111, 32'h100, 32'h12345678, 1'b1, 2'd1));
      tab.push_back(row(3'b000, 3'b010, 1'b1, 1'b0, 1'b1, SZ_WORD, 3'b111, 32'h100, 32'h12345678, 1'b1, 2'd1));
      tab.push_back(row(3'b000, 3'b010, 1'b0, 1'b0, 1'b1, SZ_WORD, 3'b101, 32'h100, 32'h12345678, 1'b1, 2'd1));
      tab.push_back(row(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 32'h0, 32'h0, 1'b0, 2'd0));
      run_tab("wr");
      req_wdata[1] = 32'h0;
      req_addr[1]  = A1;

      // 4) requester 2 abandons while memory is busy; requester 0 follows
      expect_xfer(0, 1'b1, A0, RD);
      tab.push_back(row(3'b101, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 32'h0, 32'h0, 1'b0, 2'd0));
      tab.push_back(row(3'b101, 3'b000, 1'b1, 1'b1, 1'b0, SZ_WORD, 3'b111, A2, 32'h0, 1'b1, 2'd2));
      tab.push_back(row(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, SZ_WORD, 3'b111, A2, 32'h0, 1'b1, 2'd2));
      tab.push_back(row(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 32'h0, 32'h0, 1'b0, 2'd0));
      tab.push_back(row(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, SZ_WORD, 3'b111, A0, 32'h0, 1'b1, 2'd0));
      tab.push_back(row(3'b001, 3'b000, 1'b0, 1'b1, 1'b0, SZ_WORD, 3'b110, A0, 32'h0, 1'b1, 2'd0));
      tab.push_back(row(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 32'h0, 32'h0, 1'b0, 2'd0));
      run_tab("abn");

      // 5) requester 1 asserts req_lock for 6 transfers while requester 0 waits
`ifdef MEM_SCHED_LOCK_EN
      lk_id  = '{1, 1, 1, 1, 0, 1, 1};
      lk_gap = '{1, 1, 1, 2, 2, 1};
`else
      lk_id  = '{1, 0, 1, 1, 1, 1, 1};
      lk_gap = '{2, 2, 2, 2, 2, 2};
`endif
      for (int k = 0; k < 7; k++) begin
         expect_xfer(lk_id[k], 1'b1, (lk_id[k] == 0) ? A0 : A1, RD);
      end
      n0       = done_id.size();
      n1       = 0;
      done0    = 1'b0;
      req_r    = 3'b011;
      req_lock = 3'b010;
      mem_busy = 1'b0;
      for (int c = 0; c < 40 && !(done0 && n1 == 6); c++) begin
         @(negedge clk);
         if (req_busy[0] === 1'b0) done0 = 1'b1;
         if (req_busy[1] === 1'b0) n1++;
         tick();
         if (done0) req_r[0] = 1'b0;
         if (n1 == 6) begin
            req_r[1]    = 1'b0;
            req_lock[1] = 1'b0;
         end
      end
      req_r    = 3'b000;
      req_lock = 3'b000;
      chk("lock.count", 32'(done_id.size() - n0), 32'd7);
      for (int k = 1; k < 7; k++) begin
         if (n0 + k < done_cyc.size()) begin
            chk($sformatf("lock.gap%0d", k), 32'(done_cyc[n0 + k] - done_cyc[n0 + k - 1]), 32'(lk_gap[k - 1]));
         end
      end
      repeat (3) tick();

      // 6) reset while requester 1 owns the bus; requester 0 must win afterwards
      req_r    = 3'b010;
      mem_busy = 1'b1;
      @(negedge clk);
      tick();
      req_r = 3'b111;
      @(negedge clk);
      chk("rstmid.pre_mem_r", 32'(mem_r), 32'd1);
      chk("rstmid.pre_grant", 32'(grant_id), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("rstmid.mem_r", 32'(mem_r), 32'd0);
      chk("rstmid.mem_w", 32'(mem_w), 32'd0);
      chk("rstmid.mem_addr", mem_addr, 32'd0);
      chk("rstmid.req_busy", 32'(req_busy), 32'b111);
      tick();
      expect_xfer(0, 1'b1, A0, RD);
      mem_busy = 1'b0;
      rst      = 1'b1;
      wait_done(0, 10);
      req_r = 3'b000;
      repeat (3) tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bound the whole run so a stuck design cannot hang the simulator
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_sched.md
# mem_sched

Round-robin scheduler sharing the single external memory bus among up to NREQ bus masters: the core's combined fetch/data port (requester 0), DMA, and video refresh. It sits between those masters and the memory controller. Each transaction is granted to one master at a time and held until the memory completes it. Requesters use the same r/w/sz/addr/busy handshake the core uses, so the core port connects unmodified.

## Interface
- NREQ, 3: number of requesters, 2..8; index 0 is the core.
- MAX_LOCK, 4: maximum back-to-back transfers per locked grant (used only with MEM_SCHED_LOCK_EN).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_r  in  NREQ  per-requester read strobe.
- req_w  in  NREQ  per-requester write strobe; r and w are never both high for one requester.
- req_sz  in  NREQx2  access size: 0=byte, 1=half, 2=word.
- req_addr  in  NREQx32  byte address.
- req_wdata  in  NREQx32  write data.
- req_lock  in  NREQ  keep the grant after this transfer (MEM_SCHED_LOCK_EN only).
- req_rdata  out  32  read data, broadcast to all requesters.
- req_busy  out  NREQ  stall; low only for the granted requester in its completion cycle.
- mem_r, mem_w  out  1 each  downstream strobes.
- mem_sz  out  2  downstream size.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data.
- mem_busy  in  1  downstream stall.
- grant_id  out  $clog2(NREQ)  current owner; valid while state is OWN.

## Operation
- State machine with two states:
  - ARB: no owner; downstream strobes are 0; all req_busy are 1.
  - OWN: the owner's r/w/sz/addr/wdata pass combinationally to mem_*; req_busy[owner] = mem_busy; all other req_busy = 1.
- ARB → OWN when any (req_r|req_w) is high. The winner is the first active requester after last_grant, searching upward and wrapping from NREQ-1 to 0. The winner is registered into owner and last_grant.
- OWN → ARB in the completion cycle: the owner's r|w is high and mem_busy is 0.
- OWN → ARB also when the owner drops r|w before completion (abandon). mem_* strobes fall in that same cycle; no transfer is counted.
- Requesters must hold all request signals stable until their own busy is low.
- req_rdata = mem_rdata at all times; it is valid only for the owner in its completion cycle.
- When no owner exists, mem_sz, mem_addr and mem_wdata are 0.
- Simultaneous requests: strict rotation. With requesters 0, 1 and 2 continuously active, grants run 0, 1, 2, 0, ...
- Reset mid-transfer: the state goes to ARB immediately and downstream strobes drop asynchronously. The memory side must tolerate a dropped strobe.

## Timing
- Reset values:
  - Registers: state = ARB, owner = 0, last_grant = NREQ-1 (requester 0 wins first), lock_cnt = 0.
  - Outputs: mem_r = 0, mem_w = 0, mem_sz = 0, mem_addr = 0, mem_wdata = 0, req_busy = all 1, grant_id = 0.
- Arbitration costs one cycle. A request first seen in cycle N appears on mem_* in cycle N+1. With mem_busy = 0 it completes in N+1.
- Unlocked throughput is at most one transfer per 2 cycles.
- All mem_* outputs are combinational from registered owner and requester inputs; no registers sit in the data path.
- last_grant updates only on an ARB → OWN transition.

## Configuration
- MEM_SCHED_LOCK_EN:
  - Defined: req_lock is honoured. At completion, if req_lock[owner] = 1 and lock_cnt < MAX_LOCK-1, the state stays OWN and lock_cnt increments. Otherwise the state goes to ARB and lock_cnt clears. A locked requester's next transfer can complete in the cycle after its previous one.
  - Undefined: req_lock is ignored, no lock_cnt is built, and every completion returns to ARB.

## Structure
- mem_sched_pkg holds:
  - the state enum (ARB, OWN);
  - the req_id_t index type sized from NREQ;
  - the size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD, shared with the core.
- One sub-module, rr_pick: a combinational rotating priority encoder.
  - Inputs: request vector and last_grant.
  - Outputs: winner index and an any-request flag.

## Test plan
- Reset with requesters 0 and 2 both reading → requester 0 granted first, requester 2 next; each read returns mem_rdata 0xDEADBEEF on its own completion cycle only.
- All three requesters continuously active, mem_busy = 0 → grant_id sequence 0, 1, 2, 0, 1, 2; one completion every 2 cycles.
- Requester 1 writes word 0x12345678 to 0x100 with mem_busy high for 3 cycles → req_busy[1] low only in cycle 4; mem_addr and mem_wdata stable throughout; req_busy[0] and req_busy[2] stay 1.
- Requester 2 drops req_r while mem_busy = 1 → mem_r falls the same cycle; state is ARB next cycle; requester 0 is granted after that.
- MEM_SCHED_LOCK_EN with MAX_LOCK = 4: requester 1 holds req_lock for 6 transfers while requester 0 waits → 4 consecutive transfers to requester 1, then requester 0 is granted, then requester 1 again.
- Assert rst mid-OWN → mem_r and mem_w drop immediately; after release, last_grant = NREQ-1 and requester 0 wins the next contest.
